// File: rtl/snake_motion_ctrl.sv
// rtl/snake_motion_ctrl.sv - snake head motion sequencer (keycode + frame tick -> position/heading)
//
// Purpose: decodes W/A/S/D/space keycodes, counts VGA frame ticks and steps the
// head position along the committed heading; detects wall contact (or wraps).
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   keycode    in   [7:0] USB HID keycode, 0x00 = no key
//   frame_sync in   VGA vsync level, asynchronous to Clk
//   snakeX_pos out  [9:0] head-center X
//   snakeY_pos out  [9:0] head-center Y
//   dir        out  [1:0] heading W=00 A=01 S=10 D=11
//   moving     out  high while running
//   collided   out  high after wall contact
//
// Configuration: define SNAKE_WRAP_EN to wrap at the walls instead of stopping.

module snake_motion_ctrl #(
  parameter int STEP            = 24,
  parameter int FRAMES_PER_STEP = 4,
  parameter int X_MIN           = 12,
  parameter int X_MAX           = 627,
  parameter int Y_MIN           = 12,
  parameter int Y_MAX           = 467,
  parameter int START_X         = 320,
  parameter int START_Y         = 240
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_sync,
  output logic [9:0] snakeX_pos,
  output logic [9:0] snakeY_pos,
  output logic [1:0] dir,
  output logic       moving,
  output logic       collided
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_e;

  localparam logic [1:0] DIR_W = 2'b00;
  localparam logic [1:0] DIR_A = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic [9:0]         START_X_V = 10'(START_X);
  localparam logic [9:0]         START_Y_V = 10'(START_Y);
  localparam logic [7:0]         CNT_LAST  = 8'(FRAMES_PER_STEP - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d, pend_q, pend_d;
  logic        moving_q, collided_q;
  logic        fs_meta_q, fs_sync_q, fs_prev_q;

  logic        tick;
  logic        key_vld, key_restart, step;
  logic [1:0]  key_dir;
  logic signed [10:0] nx, ny;

  // frame_sync crosses from vga_clk: two-flop synchronizer then edge detect
  assign tick = fs_sync_q & ~fs_prev_q;

  always_comb begin
    key_vld     = 1'b1;
    key_dir     = DIR_W;
    key_restart = 1'b0;
    case (keycode)
      8'h1A:   key_dir = DIR_W;
      8'h04:   key_dir = DIR_A;
      8'h16:   key_dir = DIR_S;
      8'h07:   key_dir = DIR_D;
      8'h2C:   begin key_vld = 1'b0; key_restart = 1'b1; end
      default: key_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    step    = 1'b0;
    nx      = $signed({1'b0, x_q});
    ny      = $signed({1'b0, y_q});

    case (state_q)
      S_IDLE: begin
        if (key_vld) begin
          dir_d   = key_dir;
          pend_d  = key_dir;
          cnt_d   = 8'd0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // opposite heading differs only in the MSB
        if (key_vld && (key_dir != (dir_q ^ 2'b10))) pend_d = key_dir;

        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = 8'd0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        if (step) begin
          // pend_d already includes a key accepted this cycle
          dir_d = pend_d;
          case (pend_d)
            DIR_W:   ny = ny - STEP_S;
            DIR_A:   nx = nx - STEP_S;
            DIR_S:   ny = ny + STEP_S;
            default: nx = nx + STEP_S;
          endcase
`ifdef SNAKE_WRAP_EN
          if (nx > X_MAX_S)      nx = X_MIN_S;
          else if (nx < X_MIN_S) nx = X_MAX_S;
          if (ny > Y_MAX_S)      ny = Y_MIN_S;
          else if (ny < Y_MIN_S) ny = Y_MAX_S;
          x_d = nx[9:0];
          y_d = ny[9:0];
`else
          if ((nx < X_MIN_S) || (nx > X_MAX_S) || (ny < Y_MIN_S) || (ny > Y_MAX_S)) begin
            state_d = S_DEAD;
          end else begin
            x_d = nx[9:0];
            y_d = ny[9:0];
          end
`endif
        end
      end

      S_DEAD: begin
        if (key_restart) begin
          state_d = S_IDLE;
          x_d     = START_X_V;
          y_d     = START_Y_V;
          dir_d   = DIR_W;
          pend_d  = DIR_W;
          cnt_d   = 8'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      x_q        <= START_X_V;
      y_q        <= START_Y_V;
      dir_q      <= DIR_W;
      pend_q     <= DIR_W;
      moving_q   <= 1'b0;
      collided_q <= 1'b0;
      fs_meta_q  <= 1'b0;
      fs_sync_q  <= 1'b0;
      fs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      moving_q   <= (state_d == S_RUN);
      collided_q <= (state_d == S_DEAD);
      fs_meta_q  <= frame_sync;
      fs_sync_q  <= fs_meta_q;
      fs_prev_q  <= fs_sync_q;
    end
  end

  assign snakeX_pos = x_q;
  assign snakeY_pos = y_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign collided   = collided_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb/tb_snake_motion_ctrl.sv - self-checking bench for snake_motion_ctrl

module tb_snake_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode, keycode2;
  logic       frame_sync;
  logic [9:0] x, y, x2, y2;
  logic [1:0] d, d2;
  logic       mv, col, mv2, col2;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  snake_motion_ctrl u_dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_sync(frame_sync),
    .snakeX_pos(x), .snakeY_pos(y), .dir(d), .moving(mv), .collided(col)
  );

  // second instance starts 24 px from the top wall to hit the exact boundary
  snake_motion_ctrl #(.START_Y(36)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode2), .frame_sync(frame_sync),
    .snakeX_pos(x2), .snakeY_pos(y2), .dir(d2), .moving(mv2), .collided(col2)
  );

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int ed,
                         input int em, input int ec);
    chk({tag, ".x"}, int'(x), ex);
    chk({tag, ".y"}, int'(y), ey);
    chk({tag, ".dir"}, int'(d), ed);
    chk({tag, ".moving"}, int'(mv), em);
    chk({tag, ".collided"}, int'(col), ec);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; keycode = 8'h00; keycode2 = 8'h00; frame_sync = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    @(negedge Clk);
    keycode = 8'h00;
  endtask

  // one frame pulse long enough to survive the synchronizer, then idle low
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_sync = 1'b1;
      repeat (3) @(negedge Clk);
      frame_sync = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  typedef struct {
    logic [7:0] key;
    int frames;
    int ex, ey, ed, em, ec;
  } vec_t;

  vec_t tbl[10];

  // reference model: plain position/heading arithmetic
  int m_x, m_y, m_dir, m_pend, m_cnt, m_state; // 0 idle 1 run 2 dead
  int dxs[4] = '{0, -1, 0, 1};
  int dys[4] = '{-1, 0, 1, 0};

  function automatic int key2dir(input logic [7:0] k);
    case (k)
      8'h1A: return 0;
      8'h04: return 1;
      8'h16: return 2;
      8'h07: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dir = 0; m_pend = 0; m_cnt = 0; m_state = 0;
  endtask

  task automatic model_key(input logic [7:0] k);
    int kd = key2dir(k);
    if (m_state == 2) begin
      if (k == 8'h2C) begin
        m_state = 0; m_x = 320; m_y = 240; m_dir = 0; m_pend = 0; m_cnt = 0;
      end
    end else if (m_state == 0) begin
      if (kd >= 0) begin m_dir = kd; m_pend = kd; m_state = 1; m_cnt = 0; end
    end else if (kd >= 0) begin
      if (!((kd == 0 && m_dir == 2) || (kd == 2 && m_dir == 0) ||
            (kd == 1 && m_dir == 3) || (kd == 3 && m_dir == 1)))
        m_pend = kd;
    end
  endtask

  task automatic model_frame();
    int nx, ny;
    if (m_state != 1) return;
    m_cnt++;
    if (m_cnt < 4) return;
    m_cnt = 0;
    m_dir = m_pend;
    nx = m_x + 24 * dxs[m_dir];
    ny = m_y + 24 * dys[m_dir];
`ifdef SNAKE_WRAP_EN
    if (nx > 627) nx = 12; else if (nx < 12) nx = 627;
    if (ny > 467) ny = 12; else if (ny < 12) ny = 467;
    m_x = nx; m_y = ny;
`else
    if (nx < 12 || nx > 627 || ny < 12 || ny > 467) m_state = 2;
    else begin m_x = nx; m_y = ny; end
`endif
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; keycode2 = 8'h00; frame_sync = 1'b0;

    tbl[0] = '{8'h00, 0, 320, 240, 0, 0, 0};
    tbl[1] = '{8'h07, 0, 320, 240, 3, 1, 0};
    tbl[2] = '{8'h00, 8, 368, 240, 3, 1, 0};
    tbl[3] = '{8'h04, 4, 392, 240, 3, 1, 0};
    tbl[4] = '{8'h1A, 4, 392, 216, 0, 1, 0};
    tbl[5] = '{8'h16, 4, 392, 192, 0, 1, 0};
    tbl[6] = '{8'h55, 4, 392, 168, 0, 1, 0};
    tbl[7] = '{8'h07, 4, 416, 168, 3, 1, 0};
    tbl[8] = '{8'h04, 3, 416, 168, 3, 1, 0};
    tbl[9] = '{8'h00, 1, 440, 168, 3, 1, 0};

    // table-driven run from reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].key);
      frames(tbl[i].frames);
      chk_all($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].em, tbl[i].ec);
    end

    // asynchronous reset in the middle of a run
    do_reset();
    press(8'h07);
    frames(12);
    chk("pre_reset.x", int'(x), 392);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 chk_all("async_reset", 320, 240, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_all("after_release", 320, 240, 0, 0, 0);

    // key held across the tick that fires the step applies to that step
    press(8'h07);
    frames(3);
    keycode = 8'h16;
    frames(1);
    keycode = 8'h00;
    chk_all("same_cycle", 320, 264, 2, 1, 0);

    // top wall on the main instance
    do_reset();
    press(8'h1A);
    frames(36);
    chk_all("wall_pre", 320, 24, 0, 1, 0);
    frames(4);
`ifdef SNAKE_WRAP_EN
    chk_all("wall_wrap", 320, 467, 0, 1, 0);
`else
    chk_all("wall_dead", 320, 24, 0, 0, 1);
    press(8'h07);
    frames(4);
    chk_all("dead_ignore", 320, 24, 0, 0, 1);
    press(8'h2C);
    chk_all("restart", 320, 240, 0, 0, 0);
`endif

    // exact boundary: Y=12 is legal, the next step is not
    do_reset();
    keycode2 = 8'h1A;
    @(negedge Clk);
    keycode2 = 8'h00;
    frames(4);
    chk("edge.y", int'(y2), 12);
    chk("edge.moving", int'(mv2), 1);
    chk("edge.collided", int'(col2), 0);
    frames(4);
`ifdef SNAKE_WRAP_EN
    chk("edge_wrap.y", int'(y2), 467);
    chk("edge_wrap.collided", int'(col2), 0);
`else
    chk("edge_dead.y", int'(y2), 12);
    chk("edge_dead.collided", int'(col2), 1);
    chk("edge_dead.moving", int'(mv2), 0);
`endif
    chk("edge.x", int'(x2), 320);

    // randomized keys and frames against the reference model
    do_reset();
    model_reset();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] k;
        case ($urandom_range(0, 5))
          0: k = 8'h1A;
          1: k = 8'h04;
          2: k = 8'h16;
          3: k = 8'h07;
          4: k = 8'h55;
          default: k = 8'h00;
        endcase
        if (m_state == 2 && $urandom_range(0, 1) == 1) k = 8'h2C;
        press(k);
        model_key(k);
      end else begin
        frames(1);
        model_frame();
      end
      chk_all($sformatf("rnd%0d", it), m_x, m_y, m_dir, m_state == 1 ? 1 : 0,
              m_state == 2 ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_motion_ctrl.md
# snake_motion_ctrl

Sequencer for player snake-head motion. Turns the keyboard keycode and the VGA frame sync into a registered head position (`snakeX_pos`, `snakeY_pos`) and a 2-bit heading. The renderer uses the position for sprite addressing and the heading as the select for the W/A/S/D sprite-palette mux. One instance per player; it sits between the USB keycode path and the color/background renderer.

## Interface
Parameters:
- `STEP`, 24: pixels moved per step (1..64).
- `FRAMES_PER_STEP`, 4: frame ticks per step (1..255).
- `X_MIN`, 12 / `X_MAX`, 627: legal head-center X range (24×24 sprite spans pos-12..pos+11).
- `Y_MIN`, 12 / `Y_MAX`, 467: legal head-center Y range.
- `START_X`, 320 / `START_Y`, 240: position after reset or restart.

Ports:
- `Clk` input, 1 bit: system clock. All state is on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `keycode` input, 8 bits: current USB HID keycode; 0x00 means no key.
- `frame_sync` input, 1 bit: VGA vsync level from the vga_clk domain. Asynchronous to `Clk`.
- `snakeX_pos` output, 10 bits: head-center X.
- `snakeY_pos` output, 10 bits: head-center Y.
- `dir` output, 2 bits: heading. W=2'b00, A=2'b01, S=2'b10, D=2'b11. Drives the palette-mux select directly.
- `moving` output, 1 bit: high in RUN.
- `collided` output, 1 bit: high in DEAD.

## Operation
Frame tick:
- `frame_sync` passes through a 2-flop synchronizer, then a rising-edge detect.
- The result is a 1-cycle internal `tick`.

Key decode:
- 0x1A→W, 0x04→A, 0x16→S, 0x07→D, 0x2C→restart.
- Any other code is ignored.

Reversal rule:
- In RUN, a direction key that is the opposite of the committed `dir` is ignored (W↔S, A↔D).
- Any accepted key is written to `pend_dir`.

Step counter:
- 8-bit counter, cleared on entry to RUN.
- Increments on each `tick`.
- At `FRAMES_PER_STEP-1` with `tick` high, a step fires and the counter returns to 0.

Step:
- `dir` <= `pend_dir`.
- The position moves `STEP` pixels along the new heading: W decrements Y, S increments Y, A decrements X, D increments X.
- Arithmetic is 11-bit signed, so underflow below 0 is detectable.
- Out of range means the result is < MIN or > MAX.

States:
- IDLE (reset state):
  - Position held at START; `moving`=0.
  - A direction key sets `dir`=`pend_dir`=key and goes to RUN. No reversal check applies in IDLE.
- RUN:
  - Accepts keys and fires steps.
  - An out-of-range step (non-wrap build) goes to DEAD. The position keeps its last legal value; `dir` still updates.
- DEAD:
  - `collided`=1; all keys except restart are ignored.
  - Restart (0x2C) goes to IDLE, reloads START_X/START_Y, and sets `dir`=`pend_dir`=W.

Simultaneous events:
- A key accepted in the same cycle as a step applies to that step (combinational next-dir).
- The reversal check compares against the pre-step committed `dir`.

## Timing
- Reset values (asynchronous, immediate):
  - `snakeX_pos`=START_X, `snakeY_pos`=START_Y, `dir`=2'b00, `moving`=0, `collided`=0.
  - State IDLE; step counter 0; synchronizer flops 0.
- `tick` asserts on the 3rd `Clk` edge after `frame_sync` rises. Later edges are lost if `frame_sync` is high for less than 2 `Clk` periods.
- A step fires in the `tick` cycle. Position and `dir` are visible the next cycle, so latency is 1 cycle from the tick.
- Key → IDLE-to-RUN: 1 cycle; `moving` and `dir` are visible on the next edge.
- Key → `pend_dir`: 1 cycle. `dir` changes only at a step, or on the IDLE exit.
- DEAD entry: `collided` is high the cycle after the offending tick.
- `Reset` mid-RUN: all outputs take reset values asynchronously. No step fires on the release edge.
- Outputs are registered and glitch-free. The renderer may sample them on any `vga_clk` edge outside the active region.

## Configuration
- `SNAKE_WRAP_EN` defined: an out-of-range step wraps instead of killing.
  - Above MAX → MIN; below MIN → MAX, per axis.
  - DEAD is unreachable and `collided` stays 0.
- `SNAKE_WRAP_EN` undefined: wall contact goes to DEAD as described in Operation.

## Test plan
- Reset: assert `Reset` mid-RUN at X=392 → X=320, Y=240, `dir`=00, `moving`=0, `collided`=0 in the same cycle.
- Run: keycode 0x07 in IDLE, then 8 frame pulses with FRAMES_PER_STEP=4, STEP=24 → `dir`=11, `moving`=1, X 320→344→368, Y=240.
- Reversal: heading D, press 0x04 then take a step → `dir` stays 11 and X increases by 24. Press 0x1A then take a step → `dir`=00, Y 240→216.
- Same-cycle: key 0x16 held across the `tick` that fires a step while heading D → that step moves Y+24 and `dir`=10.
- Wall (default build): heading W from Y=36, STEP=24 → step to 12 is legal; the next step (−12) gives `collided`=1, Y=12, `moving`=0. Key 0x2C → IDLE, X=320, Y=240.
- Wrap (`SNAKE_WRAP_EN`): heading A at X=12 → next step gives X=627, `collided`=0, `moving`=1.
